// File: rtl/core_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// core_result_collector_pkg
//   Shared constants for the multicore result collector: default array
//   geometry, result width, the min-tracker reset value and a small helper
//   for modulo-N index increment used by the round-robin pointer.
// ---------------------------------------------------------------------------
package core_result_collector_pkg;

  // Default array geometry; ID_W must satisfy 2**ID_W >= NUM_CORES.
  localparam int NUM_CORES_DEF  = 61;
  localparam int ID_W_DEF       = 6;
  localparam int FIFO_DEPTH_DEF = 8;

  // Width of one core's $v0 result.
  localparam int V0_W = 32;

  // Reset value of the running minimum: any real result compares below it
  // except FFFF_FFFF itself, which then leaves the tracker untouched.
  localparam logic [V0_W-1:0] MIN_RESET = 32'hFFFF_FFFF;

  // idx + 1 wrapped into [0, n).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : core_result_collector_pkg

// File: rtl/core_result_collector_if.sv
// ---------------------------------------------------------------------------
// core_result_collector_if
//   Valid/ready result stream leaving the collector.
//   out_valid    : FIFO head is valid (driven by master)
//   out_ready    : consumer accepts the head (driven by slave)
//   out_data     : head result value
//   out_core_id  : head core index
// ---------------------------------------------------------------------------
interface core_result_collector_if
  import core_result_collector_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
);

  logic            out_valid;
  logic            out_ready;
  logic [V0_W-1:0] out_data;
  logic [ID_W-1:0] out_core_id;

  modport master (
    output out_valid,
    output out_data,
    output out_core_id,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_core_id,
    output out_ready
  );

endinterface : core_result_collector_if

// File: rtl/core_result_collector_result_fifo.sv
// ---------------------------------------------------------------------------
// core_result_collector_result_fifo
//   Synchronous FIFO holding captured {core id, v0} pairs.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (pointers and hold register)
//   push_i  : write data_i (ignored when full)
//   data_i  : entry to write
//   pop_i   : drop the head entry (ignored when empty)
//   data_o  : head entry; holds the last head seen once the FIFO drains
//   full_o  : no free slot
//   empty_o : no valid entry
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   without a separate occupancy counter.
// ---------------------------------------------------------------------------
module core_result_collector_result_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] head;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  // Once empty the slot under rd_ptr is stale, so present the last real head.
  assign data_o = empty_o ? hold_q : head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (!empty_o) hold_d  = head;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty pointer.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule : core_result_collector_result_fifo

// File: rtl/core_result_collector.sv
// ---------------------------------------------------------------------------
// core_result_collector
//   Reader end of the per-core result outputs of the multicore array.
//   Detects core completions, arbitrates them round-robin into a result
//   FIFO drained over a valid/ready stream, tracks the global minimum
//   result and flags when every core has reported.
//   Clk            : system clock
//   Reset          : synchronous active-low reset
//   core_done      : per-core completion level (sticky until Reset)
//   core_v0        : flattened $v0 values, core i at [32i+31:32i]
//   out_if         : result stream (valid/ready/data/core id)
//   min_value      : smallest result captured so far
//   min_core_id    : core that produced min_value (earliest on ties)
//   reported_count : results captured, saturating at NUM_CORES
//   all_reported   : reported_count == NUM_CORES
// ---------------------------------------------------------------------------
module core_result_collector
  import core_result_collector_pkg::*;
#(
  parameter int NUM_CORES  = NUM_CORES_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [NUM_CORES*V0_W-1:0] core_v0,
  core_result_collector_if.master   out_if,
  output logic [V0_W-1:0]           min_value,
  output logic [ID_W-1:0]           min_core_id,
  output logic [ID_W:0]             reported_count,
  output logic                      all_reported
);

  localparam int SEL_W   = $clog2(NUM_CORES * V0_W);
  localparam int ENTRY_W = ID_W + V0_W;

  logic [NUM_CORES-1:0] done_q;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] rise;
  logic [NUM_CORES-1:0] grant_oh;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_valid;
  logic [SEL_W-1:0]     v0_base;
  logic [V0_W-1:0]      grant_value;

  logic [ID_W:0]        count_q, count_d;
  logic [V0_W-1:0]      min_value_q, min_value_d;
  logic [ID_W-1:0]      min_id_q, min_id_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_head;

  // -------------------------------------------------------------------------
  // Completion edge detection
  // -------------------------------------------------------------------------
  assign rise = core_done & ~done_q;

  // -------------------------------------------------------------------------
  // Round-robin arbitration: first pending index at or above rr_ptr,
  // wrapping modulo NUM_CORES. Indices >= NUM_CORES never exist in the
  // pending vector, so they can never win.
  // -------------------------------------------------------------------------
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_w       = '0;
    if (!fifo_full) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_CORES) idx = idx - NUM_CORES;
        idx_w = ID_W'(idx);
        if (!grant_valid && pending_q[idx_w]) begin
          grant_valid = 1'b1;
          grant_id    = idx_w;
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_valid) grant_oh[grant_id] = 1'b1;
  end

  // A new rise for the granted core re-arms it rather than being lost.
  assign pending_d = (pending_q & ~grant_oh) | rise;

  assign rr_ptr_d = grant_valid ? ID_W'(wrap_inc(int'(grant_id), NUM_CORES))
                                : rr_ptr_q;

  // -------------------------------------------------------------------------
  // Capture: slice the granted core's v0, count it, update the minimum.
  // -------------------------------------------------------------------------
  assign v0_base     = SEL_W'(grant_id) * SEL_W'(V0_W);
  assign grant_value = core_v0[v0_base +: V0_W];

  always_comb begin
    count_d     = count_q;
    min_value_d = min_value_q;
    min_id_d    = min_id_q;
    if (grant_valid) begin
      if (count_q != (ID_W+1)'(NUM_CORES)) count_d = count_q + 1'b1;
      // Strict compare: an equal later value leaves the earlier owner.
      if (grant_value < min_value_q) begin
        min_value_d = grant_value;
        min_id_d    = grant_id;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      done_q      <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      min_value_q <= MIN_RESET;
      min_id_q    <= '0;
    end else begin
      done_q      <= core_done;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      min_value_q <= min_value_d;
      min_id_q    <= min_id_d;
    end
  end

  // -------------------------------------------------------------------------
  // Result FIFO and output stream
  // -------------------------------------------------------------------------
  assign fifo_pop = out_if.out_valid & out_if.out_ready;

  core_result_collector_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) result_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .push_i  (grant_valid),
    .data_i  ({grant_id, grant_value}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_if.out_valid   = ~fifo_empty;
  assign out_if.out_data    = fifo_head[V0_W-1:0];
  assign out_if.out_core_id = fifo_head[ENTRY_W-1:V0_W];

  assign min_value      = min_value_q;
  assign min_core_id    = min_id_q;
  assign reported_count = count_q;
  assign all_reported   = (count_q == (ID_W+1)'(NUM_CORES));

endmodule : core_result_collector

// File: tb/tb_core_result_collector.sv
module tb_core_result_collector;

  localparam int NC = 61;
  localparam int IW = 6;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NC-1:0]     core_done;
  logic [NC*32-1:0]  core_v0;
  logic [31:0]       min_value;
  logic [IW-1:0]     min_core_id;
  logic [IW:0]       reported_count;
  logic              all_reported;

  int tests_run    = 0;
  int tests_failed = 0;

  core_result_collector_if #(.ID_W(IW)) intf ();

  core_result_collector #(.NUM_CORES(NC), .ID_W(IW), .FIFO_DEPTH(8)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .core_done      (core_done),
    .core_v0        (core_v0),
    .out_if         (intf),
    .min_value      (min_value),
    .min_core_id    (min_core_id),
    .reported_count (reported_count),
    .all_reported   (all_reported)
  );

  always #5 Clk = ~Clk;

  // Handshake log: inputs change 1 time unit after posedge, so the values at
  // negedge are what the next posedge will transfer.
  int          hs_id[$];
  logic [31:0] hs_val[$];
  always @(negedge Clk) begin
    if (Reset === 1'b1 && intf.out_valid === 1'b1 && intf.out_ready === 1'b1) begin
      hs_id.push_back(int'(intf.out_core_id));
      hs_val.push_back(intf.out_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    core_done = '0;
    core_v0 = '0;
    intf.out_ready = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic raise(input int id, input logic [31:0] v);
    core_v0[id*32 +: 32] = v;
    core_done[id] = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", intf.out_valid); end
    tests_run++; if (intf.out_data !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %0h want 0", intf.out_data); end
    tests_run++; if (intf.out_core_id !== 6'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", intf.out_core_id); end
    tests_run++; if (min_value !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL reset_min: got %0h want ffffffff", min_value); end
    tests_run++; if (min_core_id !== 6'd0) begin tests_failed++; $display("FAIL reset_min_id: got %0d want 0", min_core_id); end
    tests_run++; if (reported_count !== 7'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", reported_count); end
    tests_run++; if (all_reported !== 1'b0) begin tests_failed++; $display("FAIL reset_all: got %0b want 0", all_reported); end
    repeat (3) tick();
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_valid: got %0b want 0", intf.out_valid); end
  endtask

  task automatic test_single();
    int start;
    do_reset();
    start = hs_id.size();
    intf.out_ready = 1'b1;
    raise(5, 32'd1234);
    tick();
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid: got %0b want 0", intf.out_valid); end
    tick();
    tests_run++; if (intf.out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %0b want 1", intf.out_valid); end
    tests_run++; if (intf.out_data !== 32'd1234) begin tests_failed++; $display("FAIL single_data: got %0d want 1234", intf.out_data); end
    tests_run++; if (intf.out_core_id !== 6'd5) begin tests_failed++; $display("FAIL single_id: got %0d want 5", intf.out_core_id); end
    tests_run++; if (min_value !== 32'd1234) begin tests_failed++; $display("FAIL single_min: got %0d want 1234", min_value); end
    tests_run++; if (min_core_id !== 6'd5) begin tests_failed++; $display("FAIL single_min_id: got %0d want 5", min_core_id); end
    tests_run++; if (reported_count !== 7'd1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", reported_count); end
    tick();
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drained: got %0b want 0", intf.out_valid); end
    tests_run++; if (intf.out_data !== 32'd1234) begin tests_failed++; $display("FAIL single_hold_data: got %0d want 1234", intf.out_data); end
    repeat (3) tick();
    tests_run++; if (hs_id.size() - start !== 1) begin tests_failed++; $display("FAIL single_hs_count: got %0d want 1", hs_id.size() - start); end
  endtask

  task automatic test_same_cycle();
    int          ids[3];
    logic [31:0] vals[3];
    ids = '{3, 10, 60};
    do_reset();
    intf.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vals[k] = $urandom;
      raise(ids[k], vals[k]);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (intf.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rr_valid[%0d]: got %0b want 1", k, intf.out_valid); end
      tests_run++; if (int'(intf.out_core_id) !== ids[k]) begin tests_failed++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, intf.out_core_id, ids[k]); end
      tests_run++; if (intf.out_data !== vals[k]) begin tests_failed++; $display("FAIL rr_data[%0d]: got %0h want %0h", k, intf.out_data, vals[k]); end
    end
    tick();
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_drained: got %0b want 0", intf.out_valid); end
  endtask

  task automatic test_backpressure();
    bit          used[NC];
    int          ids[$];
    logic [31:0] vals[NC];
    int          start;
    int          r;
    int          waited;
    do_reset();
    while (ids.size() < 12) begin
      r = $urandom_range(NC - 1);
      if (!used[r]) begin used[r] = 1'b1; ids.push_back(r); end
    end
    ids.sort();
    foreach (ids[k]) begin
      vals[ids[k]] = $urandom;
      raise(ids[k], vals[ids[k]]);
    end
    repeat (20) tick();
    tests_run++; if (reported_count !== 7'd8) begin tests_failed++; $display("FAIL bp_count_full: got %0d want 8", reported_count); end
    tests_run++; if (intf.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %0b want 1", intf.out_valid); end
    tests_run++; if (int'(intf.out_core_id) !== ids[0]) begin tests_failed++; $display("FAIL bp_head_id: got %0d want %0d", intf.out_core_id, ids[0]); end
    repeat (5) tick();
    tests_run++; if (intf.out_data !== vals[ids[0]]) begin tests_failed++; $display("FAIL bp_head_stable: got %0h want %0h", intf.out_data, vals[ids[0]]); end
    start = hs_id.size();
    intf.out_ready = 1'b1;
    waited = 0;
    while (hs_id.size() - start < 12 && waited < 100) begin tick(); waited++; end
    repeat (10) tick();
    tests_run++; if (hs_id.size() - start !== 12) begin tests_failed++; $display("FAIL bp_hs_count: got %0d want 12", hs_id.size() - start); end
    for (int k = 0; k < 12; k++) begin
      if (start + k < hs_id.size()) begin
        tests_run++; if (hs_id[start+k] !== ids[k] || hs_val[start+k] !== vals[ids[k]]) begin
          tests_failed++; $display("FAIL bp_order[%0d]: got id %0d val %0h want id %0d val %0h", k, hs_id[start+k], hs_val[start+k], ids[k], vals[ids[k]]);
        end
      end
    end
    tests_run++; if (reported_count !== 7'd12) begin tests_failed++; $display("FAIL bp_count_end: got %0d want 12", reported_count); end
  endtask

  task automatic test_min_tie();
    int          ids[4];
    logic [31:0] vals[4];
    ids  = '{7, 2, 9, 1};
    vals = '{32'd500, 32'd200, 32'd200, 32'd900};
    do_reset();
    intf.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      raise(ids[k], vals[k]);
      repeat (4) tick();
      if (k == 0) begin
        tests_run++; if (min_value !== 32'd500 || min_core_id !== 6'd7) begin tests_failed++; $display("FAIL min_first: got %0d/%0d want 500/7", min_value, min_core_id); end
      end
    end
    tests_run++; if (min_value !== 32'd200) begin tests_failed++; $display("FAIL min_value: got %0d want 200", min_value); end
    tests_run++; if (min_core_id !== 6'd2) begin tests_failed++; $display("FAIL min_tie_id: got %0d want 2", min_core_id); end
    tests_run++; if (reported_count !== 7'd4) begin tests_failed++; $display("FAIL min_count: got %0d want 4", reported_count); end
    tests_run++; if (all_reported !== 1'b0) begin tests_failed++; $display("FAIL min_all: got %0b want 0", all_reported); end
  endtask

  task automatic test_all_cores();
    logic [31:0] vals[NC];
    int          rel[NC];
    int          seen[NC];
    logic [31:0] exp_min;
    int          exp_min_id;
    int          start;
    int          cyc;
    int          unique_ok;
    do_reset();
    exp_min = 32'hFFFF_FFFF;
    exp_min_id = 0;
    for (int i = 0; i < NC; i++) begin
      vals[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
      rel[i]  = $urandom_range(60);
      seen[i] = 0;
      if (vals[i] < exp_min) begin exp_min = vals[i]; exp_min_id = i; end
    end
    start = hs_id.size();
    cyc = 0;
    while ((hs_id.size() - start < NC || cyc <= 60) && cyc < 3000) begin
      for (int i = 0; i < NC; i++) if (rel[i] == cyc) raise(i, vals[i]);
      intf.out_ready = ($urandom_range(3) != 0);
      tick();
      if (cyc == 0) begin
        tests_run++; if (all_reported !== 1'b0) begin tests_failed++; $display("FAIL all_early: got %0b want 0", all_reported); end
      end
      cyc++;
    end
    intf.out_ready = 1'b1;
    repeat (30) tick();
    tests_run++; if (hs_id.size() - start !== NC) begin tests_failed++; $display("FAIL all_hs_count: got %0d want %0d", hs_id.size() - start, NC); end
    tests_run++; if (reported_count !== 7'd61) begin tests_failed++; $display("FAIL all_count: got %0d want 61", reported_count); end
    tests_run++; if (all_reported !== 1'b1) begin tests_failed++; $display("FAIL all_flag: got %0b want 1", all_reported); end
    tests_run++; if (min_value !== exp_min || int'(min_core_id) !== exp_min_id) begin
      tests_failed++; $display("FAIL all_min: got %0h/%0d want %0h/%0d", min_value, min_core_id, exp_min, exp_min_id);
    end
    for (int k = start; k < hs_id.size(); k++) begin
      if (hs_id[k] >= 0 && hs_id[k] < NC) begin
        seen[hs_id[k]]++;
        tests_run++; if (hs_val[k] !== vals[hs_id[k]]) begin tests_failed++; $display("FAIL all_value[%0d]: got %0h want %0h", hs_id[k], hs_val[k], vals[hs_id[k]]); end
      end
    end
    unique_ok = 0;
    for (int i = 0; i < NC; i++) if (seen[i] == 1) unique_ok++;
    tests_run++; if (unique_ok !== NC) begin tests_failed++; $display("FAIL all_unique: got %0d cores seen once want %0d", unique_ok, NC); end
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL all_no_repeat: got valid %0b want 0", intf.out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int k = 0; k < 4; k++) raise(20 + k, 32'd1000 + 32'(k));
    repeat (8) tick();
    tests_run++; if (reported_count !== 7'd4) begin tests_failed++; $display("FAIL rst_pre_count: got %0d want 4", reported_count); end
    Reset = 1'b0;
    core_done = '0;
    intf.out_ready = 1'b1;
    tick();
    tests_run++; if (intf.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %0b want 0", intf.out_valid); end
    tests_run++; if (reported_count !== 7'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", reported_count); end
    tests_run++; if (min_value !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL rst_min: got %0h want ffffffff", min_value); end
    tests_run++; if (intf.out_data !== 32'd0) begin tests_failed++; $display("FAIL rst_data: got %0h want 0", intf.out_data); end
    Reset = 1'b1;
    raise(0, 32'd77);
    tick();
    tick();
    tests_run++; if (intf.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_again_valid: got %0b want 1", intf.out_valid); end
    tests_run++; if (intf.out_core_id !== 6'd0 || intf.out_data !== 32'd77) begin
      tests_failed++; $display("FAIL rst_again_head: got %0d/%0d want 0/77", intf.out_core_id, intf.out_data);
    end
    tests_run++; if (reported_count !== 7'd1 || min_value !== 32'd77) begin
      tests_failed++; $display("FAIL rst_again_stats: got count %0d min %0d want 1/77", reported_count, min_value);
    end
  endtask

  initial begin
    Reset = 1'b0;
    core_done = '0;
    core_v0 = '0;
    intf.out_ready = 1'b0;
    test_reset();
    test_single();
    test_same_cycle();
    test_backpressure();
    test_min_tie();
    test_all_cores();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
